msrv32_pipe_ctrl: RTL and testbench



---
 rtl/msrv32_pkg.sv | 27 ++
 rtl/msrv32_sat_counter.sv | 33 +++
 rtl/msrv32_pipe_ctrl.sv | 178 +++++++++++++++++
 tb/tb_msrv32_pipe_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/msrv32_pkg.sv
// Shared encodings for the msrv32 pipeline sequencer.
package msrv32_pkg;

    // FSM states; the numeric values are visible on state_out for debug.
    typedef enum logic [1:0] {
        ST_RESET_HOLD = 2'd0,
        ST_RUN        = 2'd1,
        ST_WAIT       = 2'd2,
        ST_REDIRECT   = 2'd3
    } pipe_state_t;

    // PC mux source select codes.
    localparam logic [1:0] PC_BOOT = 2'b00;
    localparam logic [1:0] PC_NEXT = 2'b01;
    localparam logic [1:0] PC_TRAP = 2'b10;
    localparam logic [1:0] PC_EPC  = 2'b11;

    // Largest of three values; sizes the shared sequencing counter.
    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/msrv32_sat_counter.sv
// Loadable up/down counter that saturates at a runtime limit and at zero.
module msrv32_sat_counter
    import msrv32_pkg::*;
#(
    parameter int unsigned WIDTH = 5
) (
    input  logic             clk_in,
    input  logic             reset_in,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             inc,
    input  logic             dec,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             at_max
);

    assign at_max = (count >= limit);

    // Load has priority; inc stops at limit, dec stops at zero.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (inc && !at_max) begin
            count <= count + 1'b1;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/msrv32_pipe_ctrl.sv
// Pipeline sequencer: boot hold, redirect flushes, bus-wait stalls and timeout.
module msrv32_pipe_ctrl
    import msrv32_pkg::*;
#(
    parameter int unsigned BOOT_DELAY   = 2,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned WAIT_TIMEOUT = 16
) (
    input  logic       clk_in,
    input  logic       reset_in,
    input  logic       instr_hready_in,
    input  logic       data_hready_in,
    input  logic       mem_access_in,
    input  logic       branch_taken_in,
    input  logic       trap_taken_in,
    input  logic       mret_in,
    output logic       stall_out,
    output logic       flush_out,
    output logic [1:0] pc_sel_out,
    output logic       instr_req_out,
    output logic       timeout_out,
    output logic [1:0] state_out
);

    localparam int unsigned CNT_MAX = max3(BOOT_DELAY, FLUSH_CYCLES, WAIT_TIMEOUT);
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] BOOT_LAST  = CW'(BOOT_DELAY - 1);
    localparam logic [CW-1:0] FLUSH_LOAD = CW'(FLUSH_CYCLES - 1);
    localparam logic [CW-1:0] WAIT_MAX   = CW'(WAIT_TIMEOUT);
    localparam logic [CW-1:0] WAIT_PRE   = CW'(WAIT_TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_TOP    = CW'(CNT_MAX);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    pipe_state_t   state, next_state;
    logic          bus_wait;
    logic          redirect_evt;
    logic          cnt_load, cnt_inc, cnt_dec, cnt_at_max;
    logic [CW-1:0] cnt_load_val, cnt_limit, cnt;
    logic          timeout_d, timeout_q;

    assign bus_wait     = (mem_access_in & ~data_hready_in) | ~instr_hready_in;
    assign redirect_evt = trap_taken_in | mret_in | branch_taken_in;

    // One counter serves boot, flush and wait; only the wait count must stop at WAIT_TIMEOUT.
    assign cnt_limit = (state == ST_WAIT) ? WAIT_MAX : CNT_TOP;

    msrv32_sat_counter #(
        .WIDTH(CW)
    ) u_cnt (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .inc      (cnt_inc),
        .dec      (cnt_dec),
        .limit    (cnt_limit),
        .count    (cnt),
        .at_max   (cnt_at_max)
    );

    // State and timeout pulse registers.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state     <= ST_RESET_HOLD;
            timeout_q <= 1'b0;
        end else begin
            state     <= next_state;
            timeout_q <= timeout_d;
        end
    end

    // Next-state and counter control.
    always_comb begin
        next_state   = state;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_inc      = 1'b0;
        cnt_dec      = 1'b0;
        timeout_d    = 1'b0;
        case (state)
            ST_RESET_HOLD: begin
                cnt_inc = 1'b1;
                if (cnt == BOOT_LAST) begin
                    next_state = ST_RUN;
                    cnt_load   = 1'b1;
                end
            end
            ST_RUN: begin
                if (redirect_evt) begin
                    if (FLUSH_CYCLES > 1) begin
                        next_state   = ST_REDIRECT;
                        cnt_load     = 1'b1;
                        cnt_load_val = FLUSH_LOAD;
                    end
                end else if (bus_wait) begin
                    next_state   = ST_WAIT;
                    cnt_load     = 1'b1;
                    cnt_load_val = CNT_ONE;
                end
            end
            ST_WAIT: begin
                if (trap_taken_in) begin
                    if (FLUSH_CYCLES > 1) begin
                        next_state   = ST_REDIRECT;
                        cnt_load     = 1'b1;
                        cnt_load_val = FLUSH_LOAD;
                    end else begin
                        next_state = ST_RUN;
                    end
                end else if (bus_wait) begin
                    cnt_inc = 1'b1;
                    // Pulse only on the step onto the limit; saturation blocks repeats.
                    timeout_d = !cnt_at_max && (cnt == WAIT_PRE);
                end else begin
                    next_state = ST_RUN;
                end
            end
            ST_REDIRECT: begin
                if (trap_taken_in) begin
                    cnt_load     = 1'b1;
                    cnt_load_val = FLUSH_LOAD;
                end else begin
                    cnt_dec = 1'b1;
                    if (cnt <= CNT_ONE) begin
                        next_state = ST_RUN;
                    end
                end
            end
        endcase
    end

    // Same-cycle pipeline controls from state plus current events.
    always_comb begin
        stall_out     = 1'b0;
        flush_out     = 1'b0;
        pc_sel_out    = PC_NEXT;
        instr_req_out = 1'b1;
        case (state)
            ST_RESET_HOLD: begin
                flush_out     = 1'b1;
                pc_sel_out    = PC_BOOT;
                instr_req_out = 1'b0;
            end
            ST_RUN: begin
                if (trap_taken_in) begin
                    flush_out  = 1'b1;
                    pc_sel_out = PC_TRAP;
                end else if (mret_in) begin
                    flush_out  = 1'b1;
                    pc_sel_out = PC_EPC;
                end else if (branch_taken_in) begin
                    flush_out = 1'b1;
                end else if (bus_wait) begin
                    stall_out = 1'b1;
                end
            end
            ST_WAIT: begin
                if (trap_taken_in) begin
                    flush_out  = 1'b1;
                    pc_sel_out = PC_TRAP;
                end else if (bus_wait) begin
                    stall_out = 1'b1;
                end
            end
            ST_REDIRECT: begin
                flush_out = 1'b1;
                if (trap_taken_in) begin
                    pc_sel_out = PC_TRAP;
                end
            end
        endcase
    end

    assign timeout_out = timeout_q;
    assign state_out   = state;

endmodule

// File: tb/tb_msrv32_pipe_ctrl.sv
// Scoreboard bench for msrv32_pipe_ctrl: directed scenarios then random traffic.
module tb_msrv32_pipe_ctrl;

    localparam int unsigned BD = 2;
    localparam int unsigned FC = 2;
    localparam int unsigned WT = 16;

    logic       clk_in = 1'b0;
    logic       reset_in;
    logic       instr_hready_in, data_hready_in, mem_access_in;
    logic       branch_taken_in, trap_taken_in, mret_in;
    logic       stall_out, flush_out, instr_req_out, timeout_out;
    logic [1:0] pc_sel_out, state_out;

    msrv32_pipe_ctrl #(
        .BOOT_DELAY   (BD),
        .FLUSH_CYCLES (FC),
        .WAIT_TIMEOUT (WT)
    ) dut (
        .clk_in          (clk_in),
        .reset_in        (reset_in),
        .instr_hready_in (instr_hready_in),
        .data_hready_in  (data_hready_in),
        .mem_access_in   (mem_access_in),
        .branch_taken_in (branch_taken_in),
        .trap_taken_in   (trap_taken_in),
        .mret_in         (mret_in),
        .stall_out       (stall_out),
        .flush_out       (flush_out),
        .pc_sel_out      (pc_sel_out),
        .instr_req_out   (instr_req_out),
        .timeout_out     (timeout_out),
        .state_out       (state_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        bit stall;
        bit flush;
        int pc;
        bit req;
        bit tmo;
        int st;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: mode numbers are the documented state_out values.
    int mode, boot_elapsed, redirect_left, stall_run;
    bit tmo_next;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mode          = 0;
        boot_elapsed  = 0;
        redirect_left = 0;
        stall_run     = 0;
        tmo_next      = 1'b0;
    endtask

    // Drive one cycle of inputs, predict the DUT's response and queue it.
    task automatic step(input bit rst, input bit trap, input bit mret, input bit br,
                        input bit mem, input bit dr, input bit ir);
        exp_t e;
        int   nxt;
        bit   bw, redir;
        @(posedge clk_in);
        #1;
        reset_in        = rst;
        trap_taken_in   = trap;
        mret_in         = mret;
        branch_taken_in = br;
        mem_access_in   = mem;
        data_hready_in  = dr;
        instr_hready_in = ir;
        if (rst) model_reset();
        e     = '{stall: 1'b0, flush: 1'b0, pc: 1, req: 1'b1, tmo: tmo_next, st: mode};
        nxt   = mode;
        redir = 1'b0;
        bw    = (mem && !dr) || !ir;
        case (mode)
            0: begin
                e.flush = 1'b1;
                e.pc    = 0;
                e.req   = 1'b0;
                if (!rst) begin
                    boot_elapsed++;
                    if (boot_elapsed == BD) nxt = 1;
                end
            end
            1: begin
                if (trap || mret || br) begin
                    e.flush = 1'b1;
                    e.pc    = trap ? 2 : (mret ? 3 : 1);
                    redir   = 1'b1;
                end else if (bw) begin
                    e.stall = 1'b1;
                    nxt     = 2;
                end
            end
            2: begin
                if (trap) begin
                    e.flush = 1'b1;
                    e.pc    = 2;
                    redir   = 1'b1;
                end else if (bw) begin
                    e.stall = 1'b1;
                end else begin
                    nxt = 1;
                end
            end
            default: begin
                e.flush = 1'b1;
                if (trap) begin
                    e.pc          = 2;
                    redirect_left = FC - 1;
                end else begin
                    redirect_left--;
                    if (redirect_left == 0) nxt = 1;
                end
            end
        endcase
        if (redir) begin
            if (FC > 1) begin
                nxt           = 3;
                redirect_left = FC - 1;
            end else begin
                nxt = 1;
            end
        end
        // Timeout follows the WT-th consecutive stalled cycle.
        stall_run = e.stall ? stall_run + 1 : 0;
        tmo_next  = !rst && e.stall && (stall_run == WT);
        mode      = rst ? 0 : nxt;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 1, 1);
    endtask

    // Monitor: compare every queued expectation mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_in);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("stall_out",     stall_out,     e.stall);
                chk("flush_out",     flush_out,     e.flush);
                chk("pc_sel_out",    pc_sel_out,    e.pc);
                chk("instr_req_out", instr_req_out, e.req);
                chk("timeout_out",   timeout_out,   e.tmo);
                chk("state_out",     state_out,     e.st);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int burst;
        bit ir;
        reset_in        = 1'b1;
        instr_hready_in = 1'b1;
        data_hready_in  = 1'b1;
        mem_access_in   = 1'b0;
        branch_taken_in = 1'b0;
        trap_taken_in   = 1'b0;
        mret_in         = 1'b0;
        model_reset();

        // Reset for three cycles, then boot hold.
        repeat (3) step(1, 0, 0, 0, 0, 1, 1);
        idle(4);
        // Branch redirect.
        step(0, 0, 0, 1, 0, 1, 1);
        idle(3);
        // Data bus wait for five cycles.
        repeat (5) step(0, 0, 0, 0, 1, 0, 1);
        step(0, 0, 0, 0, 1, 1, 1);
        idle(2);
        // Instruction bus wait long enough to time out.
        repeat (20) step(0, 0, 0, 0, 0, 1, 0);
        idle(3);
        // Trap plus branch while waiting.
        repeat (2) step(0, 0, 0, 0, 0, 1, 0);
        step(0, 1, 0, 1, 0, 1, 0);
        idle(3);
        // Mret, and trap during redirect.
        step(0, 0, 1, 0, 0, 1, 1);
        idle(2);
        step(0, 0, 0, 1, 0, 1, 1);
        step(0, 1, 0, 0, 0, 1, 1);
        idle(3);

        // Asynchronous reset in the middle of a redirect cycle.
        step(0, 0, 0, 1, 0, 1, 1);
        step(0, 0, 0, 0, 0, 1, 1);
        @(negedge clk_in);
        #2;
        reset_in = 1'b1;
        #1;
        chk("async_flush",     flush_out,     1);
        chk("async_pc_sel",    pc_sel_out,    0);
        chk("async_instr_req", instr_req_out, 0);
        chk("async_state",     state_out,     0);
        chk("async_stall",     stall_out,     0);
        model_reset();
        repeat (2) step(1, 0, 0, 0, 0, 1, 1);
        idle(4);

        // Random traffic with occasional long instruction-bus waits and resets.
        burst = 0;
        for (int c = 0; c < 3000; c++) begin
            if (burst > 0) begin
                ir = 1'b0;
                burst--;
            end else if ($urandom_range(0, 39) == 0) begin
                ir    = 1'b0;
                burst = $urandom_range(1, 24);
            end else begin
                ir = ($urandom_range(0, 9) != 0);
            end
            if ($urandom_range(0, 699) == 0) begin
                repeat (2) step(1, 0, 0, 0, 0, 1, 1);
            end else begin
                step(0,
                     $urandom_range(0, 24) == 0,
                     $urandom_range(0, 19) == 0,
                     $urandom_range(0, 7) == 0,
                     $urandom_range(0, 2) == 0,
                     $urandom_range(0, 2) != 0,
                     ir);
            end
        end

        repeat (3) @(negedge clk_in);
        chk("scoreboard_drain", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
